// File: rtl/vdu_text_buffer.sv
// vdu_text_buffer
//   Character-cell frame store feeding the vdu text renderer. One byte per
//   cell, COLS x ROWS cells held in a simple dual-port RAM. The write side is
//   a console: bytes arrive over valid/ready, a cursor advances, and LF, CR,
//   BS and FF are interpreted. Scrolling rotates a circular top-row offset
//   and clears only the row that wraps around to the bottom.
//
// Ports
//   i_clk          pixel clock
//   i_rst          synchronous active-high reset; starts a full clear
//   i_read_en      read strobe from the vdu
//   i_read_addr    cell address from the vdu (BASE_ADDR is subtracted)
//   o_display_data cell byte, registered, valid one cycle after i_read_en
//   i_char         byte to print or control code
//   i_valid        i_char valid
//   o_ready        high in IDLE; a byte is taken when i_valid && o_ready
//   o_cur_col      cursor column
//   o_cur_row      cursor logical row
//   o_busy         clear or scroll in progress
module vdu_text_buffer #(
  parameter int          COLS      = 16,
  parameter int          ROWS      = 8,
  parameter int          BASE_ADDR = 0,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  localparam int         CW        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int         RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_read_en,
  input  logic [15:0]   i_read_addr,
  output logic [7:0]    o_display_data,
  input  logic [7:0]    i_char,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [CW-1:0] o_cur_col,
  output logic [RW-1:0] o_cur_row,
  output logic          o_busy
);

  localparam int N  = COLS * ROWS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   addr1_t;
  typedef logic [CW-1:0] col_t;
  typedef logic [RW-1:0] row_t;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_t;

  localparam addr1_t N_W = addr1_t'(N);

  // Reduce a value below 2*N into 0..N-1 without a divider.
  function automatic addr_t wrap_n(input addr1_t x);
    addr1_t r;
    r = (x >= N_W) ? (x - N_W) : x;
    return addr_t'(r);
  endfunction

  logic [7:0] mem_q [N];
  logic [7:0] rdata_q;

  state_t state_q;
  col_t   col_q;
  row_t   row_q;
  row_t   top_q;
  addr_t  top_base_q;   // top_q * COLS, tracked incrementally
  addr_t  cnt_q;        // cell counter for CLEAR / SCROLL
  addr_t  base_q;       // first physical cell of the CLEAR / SCROLL sweep

  // Read path
  logic [16:0] la_ext;
  logic        rd_in_range;
  addr_t       rd_pa;

  assign la_ext      = {1'b0, i_read_addr} - 17'(BASE_ADDR);
  assign rd_in_range = !la_ext[16] && (la_ext[15:0] < 16'(N));
  assign rd_pa       = wrap_n(addr1_t'(la_ext[AW-1:0]) + addr1_t'(top_base_q));

  // Out-of-range reads share the reset path so the output register can use
  // the RAM's synchronous output reset.
  always_ff @(posedge i_clk) begin
    if (i_rst || (i_read_en && !rd_in_range)) begin
      rdata_q <= '0;
    end else if (i_read_en) begin
      rdata_q <= mem_q[rd_pa];
    end
  end

  assign o_display_data = rdata_q;

  // Console decode
  logic accept, is_lf, is_cr, is_bs, is_ff, is_print, at_last_col, at_last_row, do_lf;
  addr_t cur_pa;

  assign accept      = i_valid && (state_q == S_IDLE) && !i_rst;
  assign is_lf       = (i_char == 8'h0A);
  assign is_cr       = (i_char == 8'h0D);
  assign is_bs       = (i_char == 8'h08);
  assign is_ff       = (i_char == 8'h0C);
  assign is_print    = !(is_lf || is_cr || is_bs || is_ff);
  assign at_last_col = (col_q == col_t'(COLS - 1));
  assign at_last_row = (row_q == row_t'(ROWS - 1));
  assign do_lf       = is_lf || (is_print && at_last_col);
  assign cur_pa      = wrap_n(addr1_t'(row_q) * addr1_t'(COLS) + addr1_t'(col_q)
                              + addr1_t'(top_base_q));

  // Write port
  logic       we;
  addr_t      waddr;
  logic [7:0] wdata;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = FILL_CHAR;
    case (state_q)
      S_CLEAR, S_SCROLL: begin
        we    = !i_rst;
        waddr = base_q + cnt_q;
      end
      default: begin
        we    = accept && is_print;
        waddr = cur_pa;
        wdata = i_char;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Control FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      base_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      top_q      <= '0;
      top_base_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == addr_t'(N - 1)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + addr_t'(1);
          end
        end
        S_SCROLL: begin
          if (cnt_q == addr_t'(COLS - 1)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + addr_t'(1);
          end
        end
        default: begin
          if (accept) begin
            if (is_ff) begin
              col_q      <= '0;
              row_q      <= '0;
              top_q      <= '0;
              top_base_q <= '0;
              base_q     <= '0;
              cnt_q      <= '0;
              state_q    <= S_CLEAR;
            end else if (do_lf) begin
              col_q <= '0;
              if (!at_last_row) begin
                row_q <= row_q + row_t'(1);
              end else begin
                // Old top row becomes the bottom row; sweep it with fill.
                base_q  <= top_base_q;
                cnt_q   <= '0;
                state_q <= S_SCROLL;
                if (top_q == row_t'(ROWS - 1)) begin
                  top_q      <= '0;
                  top_base_q <= '0;
                end else begin
                  top_q      <= top_q + row_t'(1);
                  top_base_q <= top_base_q + addr_t'(COLS);
                end
              end
            end else if (is_cr) begin
              col_q <= '0;
            end else if (is_bs) begin
              if (col_q != '0) col_q <= col_q - col_t'(1);
            end else begin
              col_q <= col_q + col_t'(1);
            end
          end
        end
      endcase
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = !o_ready;
  assign o_cur_col = col_q;
  assign o_cur_row = row_q;

endmodule

// File: doc/vdu_text_buffer.md
Name: vdu_text_buffer

Overview:
- Character-cell frame store that sits directly upstream of the vdu text renderer. It holds one byte per cell and answers the vdu's o_read_en/o_read_addr requests with i_display_data.
- A console-style write side accepts a byte stream over valid/ready. It maintains a cursor and handles control codes.
- Scrolling uses a circular row offset, not memory copies. It costs only one row-clear per scroll.

Parameters:
- COLS, 16, characters per row (power of two not required).
- ROWS, 8, rows on screen.
- BASE_ADDR, 0, value subtracted from i_read_addr; must match the vdu BASE_ADDR.
- FILL_CHAR, 8'h20, byte written by clear and scroll.

Ports:
- i_clk  in  1  pixel clock (clk_pix).
- i_rst  in  1  synchronous, active-high reset.
- i_read_en  in  1  read strobe from vdu.
- i_read_addr  in  16  cell address from vdu.
- o_display_data  out  8  cell byte to vdu, registered.
- i_char  in  8  byte to print or control code.
- i_valid  in  1  i_char valid.
- o_ready  out  1  byte accepted when i_valid && o_ready.
- o_cur_col  out  $clog2(COLS)  cursor column.
- o_cur_row  out  $clog2(ROWS)  cursor logical row.
- o_busy  out  1  clear or scroll in progress.

Behaviour:
- Storage: COLS*ROWS x 8 simple dual-port RAM with one write port and one read port. Inference as block RAM is required.
- Read path:
  - Logical address la = i_read_addr - BASE_ADDR.
  - If la < COLS*ROWS, physical address pa = (la + top_row*COLS) mod (COLS*ROWS).
  - o_display_data is valid exactly 1 cycle after i_read_en is high.
  - If la >= COLS*ROWS, or the subtraction underflows, o_display_data = 8'h00.
  - When i_read_en is low, o_display_data holds its value.
  - A read and a write to the same pa in the same cycle returns the old data.
  - Reads are served in every state, including CLEAR and SCROLL.
- Reset:
  - While i_rst is high: o_display_data=0, o_ready=0, o_busy=1, cursor (0,0), top_row=0, state=CLEAR with clear counter 0.
  - The first write occurs on the first clock after i_rst falls.
- FSM states: IDLE, CLEAR, SCROLL. o_ready = (state==IDLE); o_busy = !o_ready.
- CLEAR:
  - Writes FILL_CHAR to pa 0..COLS*ROWS-1, one cell per cycle.
  - After the last write, goes to IDLE. o_ready is low for exactly COLS*ROWS cycles.
- SCROLL:
  - On entry, top_row advances to (top_row+1) mod ROWS.
  - Writes FILL_CHAR to the COLS cells of physical row old_top, which becomes logical row ROWS-1.
  - Then goes to IDLE. o_ready is low for exactly COLS cycles.
  - Cursor stays at (0, ROWS-1).
- IDLE accept, decoded by i_char:
  - 8'h0A LF: col=0. If row<ROWS-1, row+1; otherwise enter SCROLL.
  - 8'h0D CR: col=0, row unchanged.
  - 8'h08 BS: if col>0, col-1; no write. At col 0, no effect.
  - 8'h0C FF: cursor (0,0), top_row=0, enter CLEAR.
  - Any other byte: write it at the cursor cell. If col<COLS-1, col+1. Otherwise apply LF semantics, including scroll at the last row.
- At most one byte is accepted per cycle. i_valid while o_ready is low is ignored; the source must hold it.
- Reset asserted mid-CLEAR or mid-SCROLL aborts the operation and restarts a full CLEAR.
- All arithmetic is width-safe: the mod for pa uses compare-and-subtract, not a divider.

Test Plan (COLS=4, ROWS=2, BASE_ADDR=0):
1. Release reset -> o_ready low for exactly 8 cycles, then high. Reads of addr 0..7 return 8'h20 one cycle after i_read_en. Cursor (0,0).
2. Send 'A','B' -> read addr 0 = 8'h41, addr 1 = 8'h42, addr 2 = 8'h20. Cursor (2,0). o_ready stays high.
3. Send "WXYZ" then 'Q' from reset -> addr 0..3 = "WXYZ", addr 4 = 'Q'. Cursor (1,1) with no busy period.
4. Send "12345678" -> after '8', o_ready low exactly 4 cycles. Addr 0..3 = "5678", addr 4..7 = 8'h20, cursor (0,1), top_row=1.
5. With content present, send 8'h0C -> o_ready low exactly 8 cycles. All 8 cells read 8'h20. Cursor (0,0). Addr 0 maps to physical 0.
6. Read addr 8 -> o_display_data 8'h00.
7. BS at cursor (0,0) -> cursor unchanged, no write.
8. Same-cycle read and write of one cell -> old value returned.
9. Assert i_rst at cycle 3 of a scroll -> full 8-cycle CLEAR follows.
